uop_sequencer: RTL and testbench

Parametrised microprogram sequencer for the curve-arithmetic engines. It replaces the fixed address-counter-plus-ROM pairing with one engine that selects a program, fetches words from an external synchronous uop ROM, and issues uops to the modular datapath over a valid/ready handshake. It latches CMP results into condition flags and skips conditional uops whose flag condition fails. It terminates on the RDY opcode once the datapath has drained.

---
 rtl/uop_sequencer.sv | 135 +++++++++++++
 tb/tb_uop_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uop_sequencer.sv
// Microprogram sequencer: fetches uops from an external synchronous ROM, evaluates
// flag conditions, issues uops over valid/ready and tracks CMP results in flags.
module uop_sequencer #(
  parameter int PROG_W   = 1,
  parameter int PC_W     = 6,
  parameter int OPCODE_W = 4,
  parameter int OPER_W   = 15,
  parameter int NFLAGS   = 3,
  parameter logic [OPCODE_W-1:0] OPCODE_CMP = 4'h1,
  parameter logic [OPCODE_W-1:0] OPCODE_RDY = 4'h0,
  localparam int UOP_W = OPCODE_W + OPER_W + 2*NFLAGS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [PROG_W-1:0]      prog_sel,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [PROG_W+PC_W-1:0] rom_addr,
  input  logic [UOP_W-1:0]       rom_data,
  output logic                   uop_valid,
  input  logic                   uop_ready,
  output logic [OPCODE_W-1:0]    uop_opcode,
  output logic [OPER_W-1:0]      uop_operands,
  input  logic                   cmp_valid,
  input  logic                   cmp_eq,
  input  logic                   dp_idle,
  output logic [NFLAGS-1:0]      flags
);

  typedef enum logic [2:0] {IDLE, FETCH, EVAL, ISSUE, WAIT_CMP, DRAIN} state_t;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [OPER_W-1:0]   oper;
    logic [NFLAGS-1:0]   mask;
    logic [NFLAGS-1:0]   match;
  } uop_t;

  state_t              state, state_d;
  logic [PC_W-1:0]     pc, pc_d;
  logic [PROG_W-1:0]   prog_q, prog_d;
  logic [NFLAGS-1:0]   flags_q, flags_d;
  logic                err_q, err_d, busy_q, busy_d, done_q, done_d;
  uop_t                uop_q, uop_d, rom_uop;
  logic                last_pc, cond_ok;

  assign rom_uop = uop_t'(rom_data);
  assign last_pc = (pc == {PC_W{1'b1}});
  assign cond_ok = ((flags_q & rom_uop.mask) == (rom_uop.match & rom_uop.mask));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= '0;
      prog_q  <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      uop_q   <= '0;
    end else begin
      state   <= state_d;
      pc      <= pc_d;
      prog_q  <= prog_d;
      flags_q <= flags_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      uop_q   <= uop_d;
    end
  end

  always_comb begin
    state_d = state;
    pc_d    = pc;
    prog_d  = prog_q;
    flags_d = flags_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    uop_d   = uop_q;
    case (state)
      IDLE: if (start) begin
        prog_d  = prog_sel;
        pc_d    = '0;
        flags_d = '0;
        err_d   = 1'b0;
        busy_d  = 1'b1;
        state_d = FETCH;
      end
      FETCH: state_d = EVAL;
      EVAL: begin
        uop_d = rom_uop;
        if (rom_uop.opcode == OPCODE_RDY) state_d = DRAIN;
        else if (cond_ok)                 state_d = ISSUE;
        else if (last_pc) begin
          err_d   = 1'b1;
          state_d = DRAIN;
        end else begin
          pc_d    = pc + PC_W'(1);
          state_d = FETCH;
        end
      end
      ISSUE: if (uop_ready) begin
        // pc saturates at the last word so the address never crosses into the next program
        if (last_pc) err_d = 1'b1;
        else         pc_d  = pc + PC_W'(1);
        if (uop_q.opcode == OPCODE_CMP) state_d = WAIT_CMP;
        else                            state_d = last_pc ? DRAIN : FETCH;
      end
      WAIT_CMP: if (cmp_valid) begin
        flags_d = {flags_q[NFLAGS-2:0], cmp_eq};
        state_d = err_q ? DRAIN : FETCH;
      end
      DRAIN: if (dp_idle) begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rom_addr     = {prog_q, pc};
  assign uop_valid    = (state == ISSUE);
  assign uop_opcode   = uop_q.opcode;
  assign uop_operands = uop_q.oper;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign flags        = flags_q;

endmodule

// File: tb/tb_uop_sequencer.sv
// Bench for uop_sequencer: ROM image + datapath responder, checked against a
// program-walking reference model.
module tb_uop_sequencer;
  localparam logic [3:0] CMP = 4'h1, RDY = 4'h0;

  logic        clk = 0, rst, start, uop_ready, cmp_valid, cmp_eq, dp_idle;
  logic [0:0]  prog_sel;
  logic        busy, done, err, uop_valid;
  logic [6:0]  rom_addr;
  logic [24:0] rom_data;
  logic [3:0]  uop_opcode;
  logic [14:0] uop_operands;
  logic [2:0]  flags;

  uop_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .prog_sel(prog_sel), .busy(busy), .done(done),
    .err(err), .rom_addr(rom_addr), .rom_data(rom_data), .uop_valid(uop_valid),
    .uop_ready(uop_ready), .uop_opcode(uop_opcode), .uop_operands(uop_operands),
    .cmp_valid(cmp_valid), .cmp_eq(cmp_eq), .dp_idle(dp_idle), .flags(flags));

  always #5 clk = ~clk;

  logic [24:0] rom [128];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int npass = 0, ntot = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [24:0] mk(input logic [3:0] op, input logic [14:0] oper,
                                     input logic [2:0] m, input logic [2:0] t);
    return {op, oper, m, t};
  endfunction

  // responder state (owned by the negedge process)
  logic [18:0] obs_q[$];
  bit   eqs [64];
  int   done_cnt = 0, pend = 0, eq_idx = 0, hold = 0, bp_low = 0, bp_bad = 0;
  int   addr_cycles [128];
  logic pend_eq, busy_q = 0;
  logic [6:0]  first_addr, ref_addr;
  logic [18:0] ref_uop;
  // knobs (owned by the initial process)
  int ready_mode = 0, cmp_delay = 0;
  bit resp_ok = 1;

  initial for (int a = 0; a < 128; a++) addr_cycles[a] = 0;

  always @(negedge clk) begin
    if (busy && !busy_q) begin eq_idx = 0; first_addr = rom_addr; end
    busy_q = busy;
    cmp_valid = 0;
    if (rst) pend = 0;
    else if (pend > 0) begin
      pend--;
      if (pend == 0) begin cmp_valid = 1; cmp_eq = pend_eq; end
    end
    dp_idle = ($urandom_range(0, 3) != 0);
    if (!busy) hold = 0;
    case (ready_mode)
      0: uop_ready = 1;
      1: uop_ready = 1'($urandom_range(0, 1));
      default: begin
        if (uop_valid && hold < 5) begin
          if (hold == 0) begin ref_uop = {uop_opcode, uop_operands}; ref_addr = rom_addr; end
          else if ({uop_opcode, uop_operands} != ref_uop || rom_addr != ref_addr) bp_bad++;
          uop_ready = 0; hold++; bp_low++;
        end else begin
          if (uop_valid && hold == 5) begin
            if ({uop_opcode, uop_operands} != ref_uop || rom_addr != ref_addr) bp_bad++;
            hold = 6;
          end
          uop_ready = 1;
        end
      end
    endcase
    if (uop_valid && uop_ready) begin
      obs_q.push_back({uop_opcode, uop_operands});
      if (uop_opcode == CMP && resp_ok) begin
        pend = (cmp_delay > 0) ? cmp_delay : $urandom_range(1, 3);
        pend_eq = eqs[eq_idx]; eq_idx++;
      end
    end
    if (done) done_cnt++;
    if (busy) addr_cycles[rom_addr]++;
  end

  // reference model: walk the program by the architectural rules
  logic [18:0] exp_q[$];
  logic [2:0]  exp_flags;
  logic        exp_err;
  int          cyc [128];

  task automatic model(input int prog);
    logic [2:0] fl; logic [24:0] w; int pc, k;
    exp_q.delete(); fl = 0; exp_err = 0; pc = 0; k = 0;
    while (1) begin
      w = rom[prog*64 + pc];
      if (w[24:21] == RDY) break;
      if ((fl & w[5:3]) == (w[2:0] & w[5:3])) begin
        exp_q.push_back(w[24:6]);
        if (w[24:21] == CMP) begin fl = {fl[1:0], eqs[k]}; k++; end
      end
      if (pc == 63) begin exp_err = 1; break; end
      pc++;
    end
    exp_flags = fl;
  endtask

  task automatic run(input int prog, input int mode, input bit poke, input string tag);
    int ob, db, n; int cb [128];
    model(prog);
    ready_mode = mode;
    ob = obs_q.size(); db = done_cnt;
    for (int a = 0; a < 128; a++) cb[a] = addr_cycles[a];
    prog_sel = 1'(prog); start = 1; @(negedge clk); start = 0;
    if (poke) begin
      repeat (4) @(negedge clk);
      prog_sel = ~prog_sel; start = 1; @(negedge clk); start = 0; prog_sel = 1'(prog);
    end
    n = 0;
    while (done_cnt == db && n < 3000) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk({tag, "_timeout"}, n < 3000, 1);
    chk({tag, "_nuops"}, obs_q.size() - ob, exp_q.size());
    foreach (exp_q[i]) if (ob + i < obs_q.size()) chk({tag, "_uop"}, obs_q[ob+i], exp_q[i]);
    chk({tag, "_flags"}, flags, exp_flags);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_done"}, done_cnt - db, 1);
    chk({tag, "_busy"}, busy, 0);
    for (int a = 0; a < 128; a++) cyc[a] = addr_cycles[a] - cb[a];
  endtask

  task automatic clear_rom();
    for (int a = 0; a < 128; a++) rom[a] = mk(RDY, 15'($urandom), 3'($urandom), 3'($urandom));
  endtask

  initial begin
    int ob, db, bl, bb, n, len;
    rst = 1; start = 0; prog_sel = 0;
    clear_rom();
    repeat (3) @(negedge clk);
    chk("rst_outs", {busy, done, err, uop_valid, rom_addr, flags, uop_opcode, uop_operands}, 0);
    rst = 0;
    @(negedge clk);

    // straight line {CMP, MOV, RDY}, eq=1 two cycles after accept
    rom[0] = mk(CMP, 15'h0123, 0, 0); rom[1] = mk(4'h2, 15'h4567, 0, 0); rom[2] = mk(RDY, 0, 0, 0);
    eqs[0] = 1; cmp_delay = 2;
    run(0, 0, 0, "t1");
    chk("t1_count", cyc[0] > 0 ? exp_q.size() : 0, 2);
    chk("t1_flags_c", flags, 3'b001);
    cmp_delay = 0;

    // conditional skip after flags = 100
    clear_rom();
    for (int i = 0; i < 3; i++) rom[i] = mk(CMP, 15'(i), 0, 0);
    rom[3] = mk(4'h3, 15'h7aaa, 3'b100, 3'b000);
    rom[4] = mk(4'h4, 15'h1555, 3'b111, 3'b100);
    rom[5] = mk(RDY, 0, 0, 0);
    eqs[0] = 1; eqs[1] = 0; eqs[2] = 0;
    run(0, 1, 0, "t2");
    chk("t2_flags_c", flags, 3'b100);
    chk("t2_last", obs_q[$], {4'h4, 15'h1555});

    // skip costs 2 cycles, issued uop with ready high costs 3
    rom[64] = mk(4'h5, 15'h0011, 3'b001, 3'b001);
    rom[65] = mk(4'h6, 15'h0022, 3'b010, 3'b010);
    rom[66] = mk(4'h7, 15'h0033, 3'b000, 3'b000);
    rom[67] = mk(RDY, 0, 0, 0);
    run(1, 0, 0, "ts");
    chk("ts_skip0", cyc[64], 2);
    chk("ts_skip1", cyc[65], 2);
    chk("ts_issue", cyc[66], 3);

    // backpressure on the first ISSUE
    clear_rom();
    rom[0] = mk(4'h9, 15'h2bcd, 0, 0); rom[1] = mk(4'ha, 15'h3def, 0, 0); rom[2] = mk(RDY, 0, 0, 0);
    bl = bp_low; bb = bp_bad;
    run(0, 2, 0, "tb");
    chk("tb_low_cycles", bp_low - bl, 5);
    chk("tb_unstable", bp_bad - bb, 0);

    // program select 1 with a start poke while busy
    for (int i = 0; i < 8; i++) rom[64+i] = mk(4'(2 + i), 15'($urandom), 0, 0);
    rom[72] = mk(RDY, 0, 0, 0);
    run(1, 1, 1, "tp");
    chk("tp_first_addr", first_addr, 7'h40);
    chk("tp_prog_q", rom_addr[6], 1);

    // run-off: 64 MOVs, no RDY
    for (int i = 0; i < 64; i++) rom[i] = mk(4'h2, 15'(i), 0, 0);
    run(0, 1, 0, "tr");
    chk("tr_err_c", err, 1);
    chk("tr_no_x40", cyc[64], 0);
    chk("tr_last_addr", rom_addr, 7'h3f);

    // async reset while waiting for a CMP result
    clear_rom();
    rom[0] = mk(CMP, 15'h0001, 0, 0); rom[1] = mk(CMP, 15'h0002, 0, 0);
    rom[2] = mk(4'h2, 15'h0003, 0, 0); rom[3] = mk(RDY, 0, 0, 0);
    eqs[0] = 1; eqs[1] = 0; ready_mode = 0;
    ob = obs_q.size(); db = done_cnt;
    prog_sel = 0; start = 1; @(negedge clk); start = 0;
    n = 0; while (obs_q.size() < ob + 1 && n < 200) begin @(negedge clk); n++; end
    resp_ok = 0;
    while (obs_q.size() < ob + 2 && n < 400) begin @(negedge clk); n++; end
    chk("rs_wait", n < 400, 1);
    @(negedge clk);
    chk("rs_flags_pre", flags, 3'b001);
    chk("rs_in_wait", {busy, uop_valid}, 2'b10);
    #2 rst = 1;
    #1 chk("rs_outs", {busy, done, err, uop_valid, rom_addr, flags, uop_opcode, uop_operands}, 0);
    @(negedge clk); rst = 0; resp_ok = 1;
    repeat (3) @(negedge clk);
    chk("rs_no_done", done_cnt - db, 0);
    rom[0] = mk(4'h2, 15'h0aa0, 0, 0); rom[1] = mk(4'h3, 15'h0bb0, 3'b111, 3'b000);
    rom[2] = mk(RDY, 0, 0, 0);
    run(0, 1, 0, "rc");
    chk("rc_flags_c", flags, 0);

    // random programs
    for (int it = 0; it < 16; it++) begin
      int p;
      clear_rom();
      p = $urandom_range(0, 1);
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) begin
        logic [3:0] op; logic [2:0] m;
        op = ($urandom_range(0, 2) == 0) ? CMP : 4'($urandom_range(2, 15));
        m  = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom);
        rom[p*64 + i] = mk(op, 15'($urandom), m, 3'($urandom));
      end
      for (int i = 0; i < 64; i++) eqs[i] = 1'($urandom);
      run(p, 1, 0, "rnd");
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
